// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with an oversampling bit timer feeding a small show-ahead FIFO.
// Frames with a bad stop bit are discarded and the receiver waits for the line to idle.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       frame_err,
   output logic       overflow,
   output logic       busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   logic          rx_meta_reg, rxs_reg, rxs_d_reg;
   state_t        state_reg, state_next;
   logic [15:0]   timer_reg, timer_next;
   logic [2:0]    idx_reg, idx_next;
   logic [7:0]    shift_reg, shift_next;
   logic          frame_err_reg, frame_err_next;
   logic          push;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          overflow_reg;
   logic          pop, full, wr_en;

   // rxs_d lets IDLE react only to a true falling edge of the synchronized line
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_reg <= 1'b1;
         rxs_reg     <= 1'b1;
         rxs_d_reg   <= 1'b1;
      end else begin
         rx_meta_reg <= rx;
         rxs_reg     <= rx_meta_reg;
         rxs_d_reg   <= rxs_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         timer_reg     <= '0;
         idx_reg       <= '0;
         shift_reg     <= '0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         timer_reg     <= timer_next;
         idx_reg       <= idx_next;
         shift_reg     <= shift_next;
         frame_err_reg <= frame_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      timer_next     = timer_reg;
      idx_next       = idx_reg;
      shift_next     = shift_reg;
      frame_err_next = 1'b0;
      push           = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!rxs_reg && rxs_d_reg) begin
               state_next = START;
               timer_next = HALF_LOAD;
            end
         end
         START: begin
            if (timer_reg == 16'd0) begin
               if (!rxs_reg) begin
                  state_next = DATA;
                  timer_next = BIT_LOAD;
                  idx_next   = 3'd0;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               timer_next = timer_reg - 16'd1;
            end
         end
         DATA: begin
            if (timer_reg == 16'd0) begin
               shift_next = {rxs_reg, shift_reg[7:1]};
               timer_next = BIT_LOAD;
               if (idx_reg == 3'd7) state_next = STOP;
               else                 idx_next   = idx_reg + 3'd1;
            end else begin
               timer_next = timer_reg - 16'd1;
            end
         end
         STOP: begin
            if (timer_reg == 16'd0) begin
               if (rxs_reg) begin
                  push       = 1'b1;
                  state_next = IDLE;
               end else begin
                  frame_err_next = 1'b1;
                  state_next     = BREAK;
               end
            end else begin
               timer_next = timer_reg - 16'd1;
            end
         end
         BREAK: begin
            if (rxs_reg) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign pop   = m_valid && m_ready;
   assign full  = (count_reg == DEPTH_C);
   // a pop in the same cycle frees the slot, so a full FIFO can still take the byte
   assign wr_en = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_reg] <= shift_reg;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         case ({wr_en, pop})
            2'b10:   count_reg <= count_reg + CNT_ONE;
            2'b01:   count_reg <= count_reg - CNT_ONE;
            default: count_reg <= count_reg;
         endcase
         if (push && full && !pop) overflow_reg <= 1'b1;
      end
   end

   assign m_valid   = (count_reg != '0);
   assign m_data    = m_valid ? mem[rd_ptr_reg] : 8'h00;
   assign frame_err = frame_err_reg;
   assign overflow  = overflow_reg;
   assign busy      = (state_reg != IDLE);

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 8..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of received-byte entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx  input  1  asynchronous UART serial line, 8N1, idle high.
REQ-006 SHALL have port m_data  output  8  head-of-FIFO byte; valid only while m_valid=1.
REQ-007 SHALL have port m_valid  output  1  FIFO non-empty.
REQ-008 SHALL have port m_ready  input  1  consumer accepts head byte when m_valid&m_ready.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-010 SHALL have port overflow  output  1  sticky; a byte was dropped because the FIFO was full.
REQ-011 SHALL have port busy  output  1  receiver FSM not in IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer reset to 1; the FSM uses only the synchronized value rxs.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK, with a bit-timer counter and a 3-bit bit index.
REQ-014 IDLE: on rxs=0 SHALL go to START and load the timer for CLKS_PER_BIT/2 (integer division) cycles.
REQ-015 START: at timer expiry, rxs=0 SHALL go to DATA with the timer loaded for CLKS_PER_BIT and index 0; rxs=1 SHALL return to IDLE (glitch rejected, no output).
REQ-016 DATA: every CLKS_PER_BIT cycles SHALL sample rxs into the shift register LSB first; after the 8th sample SHALL go to STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles SHALL sample rxs; 1 -> push byte and go to IDLE; 0 -> pulse frame_err for exactly one cycle, discard byte, go to BREAK.
REQ-018 BREAK: SHALL stay until rxs=1, then go to IDLE; no start detection while in BREAK.
REQ-019 The push SHALL be on the stop-sample cycle; m_valid SHALL rise on the next clock edge if the FIFO was empty.
REQ-020 FIFO SHALL be show-ahead: m_data equals the oldest entry whenever m_valid=1; pop on m_valid&m_ready.
REQ-021 Push with FIFO full and no pop in the same cycle SHALL drop the new byte, keep stored contents and set overflow=1.
REQ-022 Push and pop in the same cycle with FIFO full SHALL succeed: count unchanged, overflow unchanged.
REQ-023 Push and pop in the same cycle with FIFO empty is impossible (m_valid=0); a pop attempt while empty SHALL be ignored.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width SHALL be log2(FIFO_DEPTH)+1.
REQ-025 overflow SHALL clear only on reset.
REQ-026 Back-to-back frames SHALL be received with zero idle bits between stop and next start.

Reset
REQ-027 With rst_n=0 at a clock edge: FSM=IDLE, FIFO empty, m_valid=0, m_data=0, frame_err=0, overflow=0, busy=0, synchronizer=1.
REQ-028 Reset mid-frame SHALL abort the frame without pushing; reception resumes with the next falling edge after reset release.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-029 Send 0x55 with m_ready=1 -> single m_valid cycle with m_data=0x55; frame_err=0, overflow=0.
REQ-030 Drive rx low for 4 cycles then high -> FSM returns to IDLE, no m_valid, no frame_err.
REQ-031 Send 0xA5 with stop bit 0, hold rx low for 40 cycles, then high -> one frame_err pulse, no push; following frame 0x3C is received correctly.
REQ-032 Send 0x01..0x05 back-to-back with m_ready=0 -> overflow=1; drain yields 0x01,0x02,0x03,0x04 then m_valid=0.
REQ-033 FIFO full, m_ready=1 held on the stop-sample cycle of 0x06 -> 0x06 stored, overflow unchanged, count stays 4.
REQ-034 Assert rst_n=0 during data bit 3 of a frame -> all outputs at reset values; next frame 0xC3 is received correctly.
